imem_loader: RTL
================

# imem_loader

Boot-time program loader that writes the instruction memory from a byte stream while holding the CPU in reset. It accepts a length-prefixed, checksummed image over a valid/ready byte interface and drives the instruction memory write port. It releases the CPU hold once the image is verified. It sits between the host/UART receive path and `instruction_memory`, and is the writer for the port the CPU reads through `imem_addr`/`imem_data`.

## Interface
- `IMEM_DEPTH`, 256: instruction memory capacity in 32-bit words.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle pulse; begins a load from IDLE, DONE or ERR.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: loader can accept a byte.
- `imem_we` output 1: one-cycle word write strobe.
- `imem_waddr` output 32: byte address of the word being written; always word-aligned.
- `imem_wdata` output 32: word being written.
- `cpu_hold` output 1: keep the CPU in reset while high.
- `done` output 1: image loaded and checksum matched (level).
- `error` output 1: load aborted (level).

## Operation
- Stream format, all multi-byte fields little-endian:
  - 4-byte word count N;
  - N×4 payload bytes;
  - 1 checksum byte equal to the XOR of all payload bytes.
- A byte transfers on a cycle with `in_valid && in_ready`. Nothing else advances the FSM except `start`.
- FSM states:
  - IDLE: `in_ready`=0. `start` → LEN.
  - LEN: `in_ready`=1. Takes 4 bytes.
    - N > `IMEM_DEPTH` → ERR.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - DATA: `in_ready`=1. A 4-byte packer assembles each word.
    - Each 4th byte issues a write to `BASE_ADDR + 4*i`, where i counts 0..N-1.
    - After word N-1 → CSUM.
  - CSUM: `in_ready`=1. Takes 1 byte.
    - Match with running XOR → DONE.
    - Mismatch → ERR.
  - DONE: `done`=1, `cpu_hold`=0, `in_ready`=0. `start` → LEN.
  - ERR: `error`=1, `cpu_hold`=1, `in_ready`=0. `start` → LEN.
- On `start` into LEN:
  - clear word counter, byte counter and XOR accumulator;
  - clear `done` and `error`;
  - assert `cpu_hold`.
- `start` is ignored in LEN, DATA and CSUM; it does not restart a load in progress.
- Words already written before an ERR stay in memory. No rollback.
- For N = 0 the checksum is expected to be 8'h00.
- Width rules:
  - word counter is `$clog2(IMEM_DEPTH)+1` bits;
  - the N comparison uses the full 32-bit count, so N ≥ 2^31 is rejected rather than wrapping;
  - address arithmetic is 32-bit modulo.

## Timing
- Reset values:
  - `in_ready`=0, `imem_we`=0, `imem_waddr`=`BASE_ADDR`, `imem_wdata`=0;
  - `cpu_hold`=1, `done`=0, `error`=0;
  - state IDLE.
- All outputs are registered.
- `in_ready` rises the cycle after `start` is sampled.
- Write latency:
  - the 4th byte of a word is accepted at edge k;
  - `imem_we`=1 with valid `imem_waddr`/`imem_wdata` during cycle k+1, for exactly one cycle.
- Back-to-back bytes at full rate (one per cycle) are accepted with no stalls. `in_ready` never drops mid-frame.
- `done` or `error` asserts the cycle after the checksum byte is accepted. `cpu_hold` falls in the same cycle as `done` rises.
- Gaps in `in_valid` hold all state; there is no timeout.
- Reset mid-load:
  - immediately returns to IDLE with the reset values above;
  - the next load requires a new `start` and a full frame.

## Structure
- Shared package `loader_pkg`:
  - state enum (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - `LEN_BYTES`=4, `CSUM_BYTES`=1.
- One sub-module, `byte_packer`:
  - 8→32 little-endian assembler with a 2-bit byte index;
  - `word_valid` pulse;
  - `clear` input driven on `start`.
- The top level holds the FSM, word/address counters, XOR accumulator and output registers.

## Test plan
- Reset, then `start`; send N=3, words 32'h0000_0013, 32'h0010_0093, 32'hDEAD_BEEF and the correct XOR byte:
  - three `imem_we` pulses at addresses 0x0, 0x4, 0x8 with those data;
  - `done`=1 and `cpu_hold`=0 one cycle after the checksum byte.
- Same frame with a wrong checksum byte: `error`=1, `cpu_hold`=1, and all three writes still occurred.
- N=0 with checksum 8'h00: no writes, `done`=1 one cycle after the checksum byte.
- N=`IMEM_DEPTH`+1: `error`=1 one cycle after the 4th length byte, no writes, `in_ready`=0.
- `in_valid` toggled randomly during a 2-word frame: identical writes and result; `start` pulsed mid-DATA is ignored.
- Assert `rst` low after 6 payload bytes: all outputs return to reset values at once; a subsequent `start` plus full frame loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time instruction memory loader.
//   loader_state_e : FSM state encoding used by imem_loader
//   LEN_BYTES      : bytes in the little-endian word-count header
//   CSUM_BYTES     : bytes in the trailing XOR checksum
//   BYTE_IDX_W     : width of the byte-within-word index in byte_packer
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_e;

    localparam int LEN_BYTES  = 4;
    localparam int CSUM_BYTES = 1;
    localparam int BYTE_IDX_W = $clog2(LEN_BYTES);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles four consecutive stream bytes into one little-endian 32-bit word.
// The first byte lands in bits [7:0]. On the fourth byte word_valid pulses
// combinationally together with the completed word, so the caller can
// register the word on the same edge that accepts its last byte.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   clear           : restart assembly at byte 0 (new load)
//   byte_valid      : a byte is being accepted this cycle
//   byte_data [7:0] : the byte
//   word_valid      : this byte completes a word
//   word_data [31:0]: completed word (valid with word_valid)
// -----------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [23:0]           low_bytes_q, low_bytes_d;

    always_comb begin
        byte_idx_d  = byte_idx_q;
        low_bytes_d = low_bytes_q;
        if (clear) begin
            byte_idx_d  = '0;
            low_bytes_d = '0;
        end else if (byte_valid) begin
            // The index wraps 3 -> 0, so the top byte never needs storing.
            byte_idx_d = byte_idx_q + 1'b1;
            case (byte_idx_q)
                2'd0:    low_bytes_d[7:0]   = byte_data;
                2'd1:    low_bytes_d[15:8]  = byte_data;
                2'd2:    low_bytes_d[23:16] = byte_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q  <= '0;
            low_bytes_q <= '0;
        end else begin
            byte_idx_q  <= byte_idx_d;
            low_bytes_q <= low_bytes_d;
        end
    end

    assign word_valid = byte_valid && (byte_idx_q == '1);
    assign word_data  = {byte_data, low_bytes_q};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot loader: receives a length-prefixed, XOR-checksummed image over a
// valid/ready byte stream, writes it to instruction memory and holds the CPU
// in reset until the image is verified.
// Frame: 4-byte word count N (LE), N*4 payload bytes, 1 checksum byte (XOR of
// payload bytes).
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   start              : begin a load (honoured only in IDLE, DONE, ERR)
//   in_data/in_valid   : stream byte and its valid
//   in_ready           : loader accepts a byte this cycle
//   imem_we            : one-cycle word write strobe
//   imem_waddr         : word-aligned byte address of the write
//   imem_wdata         : write data
//   cpu_hold           : keep CPU in reset
//   done / error       : load verified / load aborted (levels)
// All outputs are registered.
// -----------------------------------------------------------------------------
module imem_loader
    import loader_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int CNT_W = $clog2(IMEM_DEPTH) + 1;

    loader_state_e    state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] num_words_q, num_words_d;
    logic [7:0]       xor_q, xor_d;

    logic             in_ready_q, in_ready_d;
    logic             imem_we_q, imem_we_d;
    logic [31:0]      imem_waddr_q, imem_waddr_d;
    logic [31:0]      imem_wdata_q, imem_wdata_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             fire;
    logic             load_start;
    logic             pk_valid;
    logic             pk_word_valid;
    logic [31:0]      pk_word;

    assign fire       = in_valid && in_ready_q;
    assign load_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERR));
    // The packer assembles both the length header and the payload words.
    assign pk_valid   = fire && ((state_q == ST_LEN) || (state_q == ST_DATA));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_start),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word_valid (pk_word_valid),
        .word_data  (pk_word)
    );

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        num_words_d  = num_words_q;
        xor_d        = xor_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d     = ST_LEN;
                    word_cnt_d  = '0;
                    num_words_d = '0;
                    xor_d       = '0;
                end
            end
            ST_LEN: begin
                if (pk_word_valid) begin
                    // Full 32-bit compare so huge counts are rejected, not wrapped.
                    if (pk_word > 32'(IMEM_DEPTH)) begin
                        state_d = ST_ERR;
                    end else if (pk_word == 32'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d     = ST_DATA;
                        num_words_d = pk_word[CNT_W-1:0];
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    xor_d = xor_q ^ in_data;
                end
                if (pk_word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_waddr_d = BASE_ADDR + (32'(word_cnt_q) << 2);
                    imem_wdata_d = pk_word;
                    word_cnt_d   = word_cnt_q + 1'b1;
                    if (word_cnt_d == num_words_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (fire) begin
                    state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs follow the next state so they register alongside it.
        in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
        cpu_hold_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            num_words_q  <= '0;
            xor_q        <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= BASE_ADDR;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            num_words_q  <= num_words_d;
            xor_q        <= xor_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
